uart_rx_controller: RTL and testbench

- Receive-side sequencer for the serial character path: consumes a 16x-oversampling enable tick and the raw serial line, and detects and qualifies the start bit.
- Times mid-bit sampling with an internal bit-sample counter and shifts in the data bits LSB-first.
- Checks the stop bit, then presents each completed character on a valid/ready handshake to the downstream char-detection logic.
- Sits between the baud-tick generator and the character identifier.

---
 rtl/uart_rx_controller.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: oversampled UART receiver.
// Qualifies the start bit, samples each bit mid-cell, checks the stop bit,
// and presents each character on a valid/ready handshake.
module uart_rx_controller #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    // Synchronizer and registered state
    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIDX_W-1:0]    r_bitidx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;

    // Next-state values
    logic                 w_rx_s;
    state_t               w_state_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [BIDX_W-1:0]    w_bitidx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] w_data_next;
    logic                 w_valid_next;
    logic                 w_frame_err_next;
    logic                 w_overrun_next;

    assign w_rx_s    = r_sync2;
    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

    // Two-flop synchronizer on the asynchronous serial line; idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, bit timing, shifting and output handshake decisions
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_bitidx_next    = r_bitidx;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_valid_next     = r_valid && !rx_ready;
        w_frame_err_next = 1'b0;
        w_overrun_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (sample_tick && !w_rx_s) begin
                    w_state_next = ST_START;
                    w_cnt_next   = '0;
                end
            end

            ST_START: begin
                if (sample_tick) begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_next = '0;
                        if (!w_rx_s) begin
                            w_state_next  = ST_DATA;
                            w_bitidx_next = '0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (sample_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next   = '0;
                        w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bitidx == BIDX_LAST) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_bitidx_next = r_bitidx + BIDX_W'(1);
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (sample_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = '0;
                        if (w_rx_s) begin
                            w_state_next = ST_IDLE;
                            if (!r_valid || rx_ready) begin
                                w_data_next  = r_shift;
                                w_valid_next = 1'b1;
                            end else begin
                                w_overrun_next = 1'b1;
                            end
                        end else begin
                            w_state_next     = ST_WAIT_HIGH;
                            w_frame_err_next = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_WAIT_HIGH: begin
                // a held-low line must return high before a new start is accepted
                if (sample_tick && w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bitidx    <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_bitidx    <= w_bitidx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Testbench for uart_rx_controller: frame-level timing model plus directed checks.
module tb_uart_rx_controller;

    localparam int unsigned OS = 16;
    localparam int unsigned DB = 8;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          sample_tick = 1'b0;
    logic          rx_in       = 1'b1;
    logic          rx_ready    = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // edge counter, ready as seen at the last edge, tick period in cycles
    int   cyc    = 0;
    logic rdy_q  = 1'b0;
    int   tp     = 1;
    bit   chk_en = 1'b0;

    // model: events keyed by the clock edge on which they must take effect
    int         ev_kind [int];   // 1 = good stop (deliver), 2 = bad stop
    logic [7:0] ev_data [int];
    logic       busy_ev [int];
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_busy  = 1'b0;
    logic [7:0] m_data  = 8'h00;

    // observation counters
    int         rise_cnt       = 0;
    int         vhigh_cnt      = 0;
    int         ferr_cnt       = 0;
    int         ovr_cnt        = 0;
    int         last_rise_edge = 0;
    logic [7:0] last_rise_data = 8'h00;
    logic       last_valid     = 1'b0;
    int         last_f         = 0;

    uart_rx_controller #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick),
        .rx_in      (rx_in),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int next_tick(input int e);
        return ((e + tp - 1) / tp) * tp;
    endfunction

    // edge bookkeeping
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= rx_ready;
    end

    // tick generator: one tick on every tp-th edge
    always @(negedge clk) begin
        sample_tick = (((cyc + 1) % tp) == 0);
    end

    // model update and per-cycle comparison of every output
    always @(negedge clk) begin
        logic prev_v;
        if (chk_en && rst_n) begin
            prev_v = m_valid;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (prev_v && rdy_q) m_valid = 1'b0;
            if (ev_kind.exists(cyc)) begin
                if (ev_kind[cyc] == 1) begin
                    if (!prev_v || rdy_q) begin
                        m_valid = 1'b1;
                        m_data  = ev_data[cyc];
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                end
                ev_kind.delete(cyc);
            end
            if (busy_ev.exists(cyc)) begin
                m_busy = busy_ev[cyc];
                busy_ev.delete(cyc);
            end
            check("rx_valid",  int'(rx_valid),  int'(m_valid));
            check("rx_data",   int'(rx_data),   int'(m_data));
            check("frame_err", int'(frame_err), int'(m_ferr));
            check("overrun",   int'(overrun),   int'(m_ovr));
            check("busy",      int'(busy),      int'(m_busy));
            if (rx_valid && !last_valid) begin
                rise_cnt++;
                last_rise_edge = cyc;
                last_rise_data = rx_data;
            end
            if (rx_valid)  vhigh_cnt++;
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
            last_valid = rx_valid;
        end
    end

    task automatic model_clear();
        ev_kind.delete();
        ev_data.delete();
        busy_ev.delete();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; predict the stop-sample edge from the tick grid.
    task automatic send_char(input logic [7:0] d, input logic stop_bit,
                             input bit ready_at_stop, input int abort_after);
        logic [9:0] fr;
        int f;
        int t0;
        int s;
        int k;
        fr = {stop_bit, d, 1'b0};
        k  = 0;
        s  = 0;
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < int'(OS) * tp; c++) begin
                @(negedge clk);
                if (abort_after > 0 && k == abort_after) begin
                    #2;
                    rst_n = 1'b0;
                    model_clear();
                    return;
                end
                rx_in = fr[j];
                if (k == 0) begin
                    f  = cyc + 1;
                    t0 = next_tick(f + 2);
                    s  = t0 + (int'(OS) / 2 + int'(OS) * (int'(DB) + 1)) * tp;
                    busy_ev[t0] = 1'b1;
                    if (stop_bit) begin
                        ev_kind[s] = 1;
                        ev_data[s] = d;
                        busy_ev[s] = 1'b0;
                    end else begin
                        ev_kind[s] = 2;
                    end
                    last_f = f;
                end
                if (ready_at_stop) begin
                    if (cyc + 1 == s) rx_ready = 1'b1;
                    else if (cyc == s) rx_ready = 1'b0;
                end
                k++;
            end
        end
    endtask

    // Three-cycle low pulse from idle: a false start.
    task automatic glitch();
        int f;
        int t0;
        @(negedge clk);
        rx_in = 1'b0;
        f  = cyc + 1;
        t0 = next_tick(f + 2);
        busy_ev[t0] = 1'b1;
        busy_ev[t0 + (int'(OS) / 2) * tp] = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rx_in = 1'b1;
    endtask

    // Release a held-low line; the receiver returns to idle on the first tick seeing it high.
    task automatic line_high();
        int h;
        @(negedge clk);
        rx_in = 1'b1;
        h = cyc + 1;
        busy_ev[next_tick(h + 2)] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog edge=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int br;
        int bv;
        int bf;
        int bo;
        int lat;

        repeat (4) @(negedge clk);
        check("reset_rx_valid",  int'(rx_valid),  0);
        check("reset_rx_data",   int'(rx_data),   0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun",   int'(overrun),   0);
        check("reset_busy",      int'(busy),      0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(10);

        // 1: clean 0x55 with ready held high
        rx_ready = 1'b1;
        br = rise_cnt; bv = vhigh_cnt; bf = ferr_cnt;
        send_char(8'h55, 1'b1, 1'b0, 0);
        idle(30);
        check("t1_rise",    rise_cnt - br, 1);
        check("t1_data",    int'(last_rise_data), 8'h55);
        check("t1_latency", last_rise_edge - (last_f - 1), 155);
        check("t1_vhigh",   vhigh_cnt - bv, 1);
        check("t1_ferr",    ferr_cnt - bf, 0);
        check("t1_busy",    int'(busy), 0);

        // 2: glitch is rejected
        br = rise_cnt; bf = ferr_cnt; bo = ovr_cnt;
        glitch();
        idle(30);
        check("t2_rise", rise_cnt - br, 0);
        check("t2_ferr", ferr_cnt - bf, 0);
        check("t2_ovr",  ovr_cnt - bo, 0);
        check("t2_busy", int'(busy), 0);

        // 3: bad stop, held-low line, then recovery
        br = rise_cnt; bf = ferr_cnt;
        send_char(8'hA3, 1'b0, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx_in = 1'b0;
            if (i == 20) check("t3_wait_busy", int'(busy), 1);
        end
        line_high();
        idle(20);
        check("t3_ferr", ferr_cnt - bf, 1);
        check("t3_rise", rise_cnt - br, 0);
        check("t3_busy", int'(busy), 0);
        br = rise_cnt;
        send_char(8'h0F, 1'b1, 1'b0, 0);
        idle(30);
        check("t3_rise_0f", rise_cnt - br, 1);
        check("t3_data_0f", int'(last_rise_data), 8'h0F);

        // 4: overrun while the first character is still unread
        rx_ready = 1'b0;
        bo = ovr_cnt;
        send_char(8'h12, 1'b1, 1'b0, 0);
        idle(20);
        check("t4_valid_12", int'(rx_valid), 1);
        check("t4_data_12",  int'(rx_data), 8'h12);
        send_char(8'h34, 1'b1, 1'b0, 0);
        idle(20);
        check("t4_ovr",      ovr_cnt - bo, 1);
        check("t4_data_kept", int'(rx_data), 8'h12);
        check("t4_valid_kept", int'(rx_valid), 1);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        idle(3);
        check("t4_drained", int'(rx_valid), 0);

        // 5: ready on the completing edge replaces the held character
        bo = ovr_cnt;
        send_char(8'h12, 1'b1, 1'b0, 0);
        idle(20);
        send_char(8'h34, 1'b1, 1'b1, 0);
        idle(20);
        check("t5_valid", int'(rx_valid), 1);
        check("t5_data",  int'(rx_data), 8'h34);
        check("t5_ovr",   ovr_cnt - bo, 0);

        // 6: slow ticks, reset mid-data, then a clean character
        tp = 4;
        idle(12);
        send_char(8'hC6, 1'b1, 1'b0, 300);
        #1;
        check("t6_rst_rx_valid",  int'(rx_valid),  0);
        check("t6_rst_rx_data",   int'(rx_data),   0);
        check("t6_rst_frame_err", int'(frame_err), 0);
        check("t6_rst_overrun",   int'(overrun),   0);
        check("t6_rst_busy",      int'(busy),      0);
        rx_in = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        rx_ready = 1'b1;
        br = rise_cnt;
        send_char(8'h81, 1'b1, 1'b0, 0);
        idle(60);
        lat = last_rise_edge - (last_f - 1);
        check("t6_rise", rise_cnt - br, 1);
        check("t6_data", int'(last_rise_data), 8'h81);
        check("t6_latency_in_611_614", int'(lat >= 611 && lat <= 614), 1);
        check("t6_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
